// File: rtl/img_xform_pkg.sv
// Shared types and helpers for the frame-buffer transform engine.
package img_xform_pkg;

  typedef enum logic [2:0] {
    MODE_PASS      = 3'b000,
    MODE_ROT_CCW   = 3'b001,
    MODE_HFLIP     = 3'b010,
    MODE_VFLIP     = 3'b011,
    MODE_ROT_CW    = 3'b100,
    MODE_ROT180    = 3'b101,
    MODE_TRANSPOSE = 3'b110,
    MODE_RSVD      = 3'b111
  } xform_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } state_e;

  function automatic logic mode_is_rotated(input xform_mode_e mode);
    return (mode == MODE_ROT_CCW) || (mode == MODE_ROT_CW) || (mode == MODE_TRANSPOSE);
  endfunction

  // Output width (want_h=0) or height (want_h=1); rotated modes swap the axes.
  function automatic int out_dim(input xform_mode_e mode, input int img_w, input int img_h,
                                 input logic want_h);
    return (mode_is_rotated(mode) ^ want_h) ? img_h : img_w;
  endfunction

endpackage

// File: rtl/sram.sv
// Single-port frame store with one-cycle registered read; contents survive reset.
module sram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/xform_addr_gen.sv
// Output raster counters plus the per-mode source-pixel to SRAM-address mapping.
module xform_addr_gen
  import img_xform_pkg::*;
#(
  parameter int IMG_W  = 1024,
  parameter int IMG_H  = 1024,
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic [2:0]        i_mode,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_col,
  output logic              o_last
);

  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(IMG_H - 1);

  xform_mode_e      w_mode;
  logic [CNT_W-1:0] r_ox, r_oy;
  logic [CNT_W-1:0] w_ox_max, w_oy_max;
  logic [CNT_W-1:0] w_sx, w_sy;

  assign w_mode   = xform_mode_e'(i_mode);
  assign w_ox_max = CNT_W'(out_dim(w_mode, IMG_W, IMG_H, 1'b0) - 1);
  assign w_oy_max = CNT_W'(out_dim(w_mode, IMG_W, IMG_H, 1'b1) - 1);

  assign o_last_col = (r_ox == w_ox_max);
  assign o_last     = o_last_col && (r_oy == w_oy_max);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ox <= '0;
      r_oy <= '0;
    end else if (i_step) begin
      if (r_ox == w_ox_max) begin
        r_ox <= '0;
        r_oy <= (r_oy == w_oy_max) ? '0 : r_oy + 1'b1;
      end else begin
        r_ox <= r_ox + 1'b1;
      end
    end
  end

  always_comb begin
    w_sx = r_ox;
    w_sy = r_oy;
    case (w_mode)
      MODE_ROT_CCW:   begin w_sx = W_MAX - r_oy; w_sy = r_ox;         end
      MODE_HFLIP:     begin w_sx = W_MAX - r_ox;                      end
      MODE_VFLIP:     begin w_sy = H_MAX - r_oy;                      end
      MODE_ROT_CW:    begin w_sx = r_oy;         w_sy = H_MAX - r_ox; end
      MODE_ROT180:    begin w_sx = W_MAX - r_ox; w_sy = H_MAX - r_oy; end
      MODE_TRANSPOSE: begin w_sx = r_oy;         w_sy = r_ox;         end
      default:        ;
    endcase
  end

  assign o_addr = ADDR_W'(w_sy) * ADDR_W'(IMG_W) + ADDR_W'(w_sx);

endmodule

// File: rtl/img_xform_engine.sv
// Stores one raster frame, then replays it under a geometric transform with
// valid/ready flow control on both sides and a credit-limited 2-entry output buffer.
module img_xform_engine
  import img_xform_pkg::*;
#(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 1024,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic             cmd_load,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_last_col,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int DEPTH   = IMG_W * IMG_H;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CNT_W   = $clog2(MAX_DIM);

  state_e            r_state, w_state_next;
  logic [2:0]        r_mode;
  logic              r_frame_valid, r_prime, r_issued_all, r_done, r_err;
  logic              w_accept, w_reject, w_load_beat, w_issue, w_pop, w_push, w_finish;
  logic [2:0]        w_credit, w_ag_mode;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ag_last_col, w_ag_last;
  logic              r_rd_vld, r_rd_last_col, r_rd_last;
  logic [PIX_W-1:0]  w_rdata;
  logic [PIX_W-1:0]  r_buf_data [2];
  logic [1:0]        r_buf_lc, r_buf_last;
  logic              r_wr_ptr, r_rd_ptr;
  logic [1:0]        r_occ;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    cmd_ready    = 1'b0;
    s_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_mode == 3'(MODE_RSVD) || (!cmd_load && !r_frame_valid)) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = cmd_load ? ST_LOAD : ST_READ;
          end
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid && w_ag_last) w_state_next = ST_READ;
      end
      ST_READ: begin
        if (w_finish) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_load_beat = (r_state == ST_LOAD) && s_valid;
  assign m_valid     = (r_occ != 2'd0);
  assign w_pop       = m_valid && m_ready;
  assign w_finish    = (r_state == ST_READ) && w_pop && m_last;
  assign w_push      = r_rd_vld;

  // Room check counts the read already in the SRAM pipe and the slot freed this cycle.
  assign w_credit = {1'b0, r_occ} + {2'b0, r_rd_vld} - {2'b0, w_pop};
  assign w_issue  = (r_state == ST_READ) && !r_prime && !r_issued_all && (w_credit < 3'd2);

  // Loading walks the store in plain raster order, so it reuses the generator in PASS.
  assign w_ag_mode = (r_state == ST_LOAD) ? 3'(MODE_PASS) : r_mode;

  xform_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_accept || r_prime),
    .i_step    (w_load_beat || w_issue),
    .i_mode    (w_ag_mode),
    .o_addr    (w_addr),
    .o_last_col(w_ag_last_col),
    .o_last    (w_ag_last)
  );

  sram #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W),
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk    (clk),
    .i_we   (w_load_beat),
    .i_re   (w_issue),
    .i_addr (w_addr),
    .i_wdata(s_data),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mode        <= '0;
      r_frame_valid <= 1'b0;
      r_prime       <= 1'b0;
      r_issued_all  <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_rd_vld      <= 1'b0;
      r_rd_last_col <= 1'b0;
      r_rd_last     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_finish;
      r_err   <= w_reject;
      if (w_accept) r_mode <= cmd_mode;
      if (w_load_beat && w_ag_last) r_frame_valid <= 1'b1;
      // First READ cycle re-zeroes the counters under the latched mode before issuing.
      r_prime <= (w_state_next == ST_READ) && (r_state != ST_READ);
      if (r_prime) r_issued_all <= 1'b0;
      else if (w_issue && w_ag_last) r_issued_all <= 1'b1;
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_last_col <= w_ag_last_col;
        r_rd_last     <= w_ag_last;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    always_ff @(posedge clk) begin
      if (rst) begin
        r_buf_data[gi] <= '0;
        r_buf_lc[gi]   <= 1'b0;
        r_buf_last[gi] <= 1'b0;
      end else if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_buf_data[gi] <= w_rdata;
        r_buf_lc[gi]   <= r_rd_last_col;
        r_buf_last[gi] <= r_rd_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign m_data     = r_buf_data[r_rd_ptr];
  assign m_last_col = r_buf_lc[r_rd_ptr];
  assign m_last     = r_buf_last[r_rd_ptr];
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_img_xform_engine.sv
// Randomised bench for img_xform_engine on a 4x3 frame with an image-operation reference model.
module tb_img_xform_engine;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int PW    = 8;
  localparam int DEPTH = W * H;

  typedef int img_q_t[$];

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_load, s_valid, m_ready;
  logic [2:0]    cmd_mode;
  logic [PW-1:0] s_data;
  logic          cmd_ready, s_ready, m_valid, m_last_col, m_last, busy, done, err;
  logic [PW-1:0] m_data;

  int     total = 0;
  int     bad   = 0;
  int     pix_src [DEPTH];
  img_q_t model_img;

  always #5 clk = ~clk;

  img_xform_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_load(cmd_load),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last_col(m_last_col), .m_last(m_last),
    .busy(busy), .done(done), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: image operations on a row-major w x h picture.
  function automatic img_q_t hflip(input img_q_t a, input int w, input int h);
    img_q_t r;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) r.push_back(a[y*w + (w-1-x)]);
    return r;
  endfunction

  function automatic img_q_t vflip(input img_q_t a, input int w, input int h);
    img_q_t r;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) r.push_back(a[(h-1-y)*w + x]);
    return r;
  endfunction

  function automatic img_q_t transpose(input img_q_t a, input int w, input int h);
    img_q_t r;
    for (int y = 0; y < w; y++)
      for (int x = 0; x < h; x++) r.push_back(a[x*w + y]);
    return r;
  endfunction

  function automatic img_q_t expected_img(input int mode);
    case (mode)
      1:       return vflip(transpose(model_img, W, H), H, W);
      2:       return hflip(model_img, W, H);
      3:       return vflip(model_img, W, H);
      4:       return hflip(transpose(model_img, W, H), H, W);
      5:       return hflip(vflip(model_img, W, H), W, H);
      6:       return transpose(model_img, W, H);
      default: return model_img;
    endcase
  endfunction

  task automatic check_idle_outputs(input string name);
    total++;
    if (cmd_ready !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 ||
        m_last_col !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s: got cr=%b sr=%b mv=%b md=%0d lc=%b l=%b busy=%b done=%b err=%b want 1 0 0 0 0 0 0 0 0",
               name, cmd_ready, s_ready, m_valid, m_data, m_last_col, m_last, busy, done, err);
    end
  endtask

  task automatic run_frame(input int mode, input bit load, input int ready_pct, input bit gaps,
                           input bit chk_lat);
    img_q_t        exp_q;
    int            ow, n, cyc, idx, first_cyc, last_cyc;
    bit            held, err_seen, sready_seen;
    logic [PW-1:0] h_data;
    logic          h_lc, h_last;
    logic [PW+1:0] got, want;
    err_seen    = 1'b0;
    sready_seen = 1'b0;
    cmd_valid = 1'b1; cmd_mode = 3'(mode); cmd_load = load;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_ready_m%0d: got %b want 1", mode, cmd_ready);
    end
    step();
    // Keep an illegal command asserted while busy; it must be ignored.
    cmd_mode = 3'b111; cmd_load = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_after_accept_m%0d: got %b want 1", mode, busy);
    end
    if (load) begin
      n = 0; cyc = 0;
      while (n < DEPTH && cyc < 500) begin
        if (err) err_seen = 1'b1;
        s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data  = PW'(pix_src[n]);
        if (s_valid && s_ready) n++;
        step(); cyc++;
      end
      s_valid = 1'b0;
      total++;
      if (n < DEPTH) begin
        bad++; $display("FAIL load_timeout_m%0d: got %0d beats want %0d", mode, n, DEPTH);
      end
      model_img = {};
      for (int i = 0; i < DEPTH; i++) model_img.push_back(pix_src[i] & 8'hff);
    end
    exp_q = expected_img(mode);
    ow = (mode == 1 || mode == 4 || mode == 6) ? H : W;
    idx = 0; cyc = 0; first_cyc = -1; last_cyc = -1; held = 1'b0;
    while (idx < DEPTH && cyc < 1000) begin
      if (err) err_seen = 1'b1;
      if (s_ready) sready_seen = 1'b1;
      if (held) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== h_data || m_last_col !== h_lc || m_last !== h_last) begin
          bad++;
          $display("FAIL stall_hold_m%0d_beat%0d: got v=%b d=%0d lc=%b l=%b want v=1 d=%0d lc=%b l=%b",
                   mode, idx, m_valid, m_data, m_last_col, m_last, h_data, h_lc, h_last);
        end
      end
      m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      held = 1'b0;
      if (m_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (m_ready) begin
          got  = {m_data, m_last_col, m_last};
          want = {PW'(exp_q[idx]), 1'((idx % ow) == ow - 1), 1'(idx == DEPTH - 1)};
          total++;
          if (got !== want) begin
            bad++;
            $display("FAIL beat_m%0d_%0d: got d=%0d lc=%b l=%b want d=%0d lc=%b l=%b", mode, idx,
                     got[PW+1:2], got[1], got[0], want[PW+1:2], want[1], want[0]);
          end
          idx++; last_cyc = cyc;
          if (idx == DEPTH) cmd_valid = 1'b0;
        end else begin
          held = 1'b1; h_data = m_data; h_lc = m_last_col; h_last = m_last;
        end
      end
      step(); cyc++;
    end
    m_ready = 1'b0; cmd_valid = 1'b0;
    total++;
    if (idx < DEPTH) begin
      bad++; $display("FAIL read_timeout_m%0d: got %0d beats want %0d", mode, idx, DEPTH);
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL done_cycle_m%0d: got done=%b busy=%b cr=%b want 1 0 1", mode, done, busy, cmd_ready);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL done_pulse_m%0d: got %b want 0", mode, done);
    end
    total++;
    if (err_seen || sready_seen) begin
      bad++; $display("FAIL busy_ignore_m%0d: got err=%b s_ready=%b want 0 0", mode, err_seen, sready_seen);
    end
    if (chk_lat) begin
      total++;
      if (first_cyc != 3) begin
        bad++; $display("FAIL first_latency_m%0d: got %0d want 3", mode, first_cyc);
      end
      total++;
      if (last_cyc - first_cyc != DEPTH - 1) begin
        bad++; $display("FAIL throughput_m%0d: got %0d want %0d", mode, last_cyc - first_cyc, DEPTH - 1);
      end
    end
  endtask

  task automatic send_reject(input int mode, input bit load, input string name);
    cmd_valid = 1'b1; cmd_mode = 3'(mode); cmd_load = load;
    step();
    cmd_valid = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      bad++; $display("FAIL %s: got err=%b busy=%b sr=%b want 1 0 0", name, err, busy, s_ready);
    end
    step();
    total++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_pulse: got err=%b busy=%b want 0 0", name, err, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_load = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    check_idle_outputs("reset_state");
  endtask

  task automatic test_errors();
    send_reject(0, 1'b0, "reuse_without_frame");
    send_reject(7, 1'b1, "reserved_mode");
  endtask

  task automatic test_pass();
    for (int i = 0; i < DEPTH; i++) pix_src[i] = i;
    run_frame(0, 1'b1, 100, 1'b0, 1'b1);
  endtask

  task automatic test_rot_cw();
    run_frame(4, 1'b1, 100, 1'b1, 1'b1);
  endtask

  task automatic test_rot_ccw_reuse();
    run_frame(1, 1'b0, 100, 1'b0, 1'b1);
  endtask

  task automatic test_hflip_stall();
    run_frame(2, 1'b0, 50, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) pix_src[i] = int'($urandom_range(0, 255));
      run_frame(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 70, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid_read();
    int n, cyc;
    cmd_valid = 1'b1; cmd_mode = 3'b000; cmd_load = 1'b0;
    step();
    cmd_valid = 1'b0;
    m_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      if (m_valid) n++;
      step(); cyc++;
    end
    total++;
    if (n < 5) begin
      bad++; $display("FAIL abort_timeout: got %0d beats want 5", n);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("abort_state");
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (m_valid !== 1'b0) begin
        bad++; $display("FAIL abort_flush_%0d: got m_valid=%b want 0", i, m_valid);
      end
    end
    m_ready = 1'b0;
    send_reject(0, 1'b0, "reuse_after_abort");
  endtask

  initial begin
    test_reset();
    test_errors();
    test_pass();
    test_rot_cw();
    test_rot_ccw_reuse();
    test_hflip_stall();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
